// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b (a + ~b + 1), LSB first, one full-adder cell per clock
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;

  logic             s;
  logic             cout;
  logic             last_bit;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    s        = sa[0] ^ sb[0] ^ carry;
    cout     = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & carry);
    res_nxt  = {s, res[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start is only honoured in IDLE and DONE, so a start during RUN never disturbs the operation
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (load) begin
      sa    <= bus.a;
      sb    <= ~bus.b;
      res   <= '0;
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      res   <= res_nxt;
      carry <= cout;
      cnt   <= cnt + CW'(1);
      // On the MSB, carry is the carry into the sign bit and cout the carry out of it
      if (last_bit) begin
        diff_q   <= res_nxt;
        borrow_q <= ~cout;
        ovf_q    <= carry ^ cout;
        zero_q   <= (res_nxt == '0);
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero       = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed-vector self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int busy_cnt, output int overlap);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = 8'hA5;
    lat      = 0;
    busy_cnt = 0;
    overlap  = 0;
    while (lat < 30) begin
      @(negedge clk);
      if (bus.busy && bus.done) overlap++;
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.diff, bus.borrow_out, bus.overflow, bus.zero} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b ov=%b z=%b, expected all 0",
               bus.busy, bus.done, bus.diff, bus.borrow_out, bus.overflow, bus.zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc, ov;
    run_op(8'h5A, 8'h23, lat, bc, ov);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d, expected 8", lat); end
    n_checks++;
    if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, expected 8", bc); end
    n_checks++;
    if (ov !== 0) begin n_fail++; $display("FAIL basic_busy_done_overlap: got %0d, expected 0", ov); end
    n_checks++;
    if ({bus.diff, bus.borrow_out, bus.overflow, bus.zero} !== {8'h37, 3'b000}) begin
      n_fail++;
      $display("FAIL basic_result: got diff=%h bo=%b ov=%b z=%b, expected diff=37 bo=0 ov=0 z=0",
               bus.diff, bus.borrow_out, bus.overflow, bus.zero);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got done=%b, expected 0", bus.done); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.diff !== 8'h37 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got diff=%h busy=%b, expected diff=37 busy=0", bus.diff, bus.busy);
    end
  endtask

  task automatic test_borrow;
    int lat, bc, ov;
    run_op(8'h10, 8'h20, lat, bc, ov);
    n_checks++;
    if (lat !== 8 || {bus.diff, bus.borrow_out, bus.overflow, bus.zero} !== {8'hF0, 3'b100}) begin
      n_fail++;
      $display("FAIL borrow_10_20: got lat=%0d diff=%h bo=%b ov=%b z=%b, expected lat=8 diff=f0 bo=1 ov=0 z=0",
               lat, bus.diff, bus.borrow_out, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_overflow;
    int lat, bc, ov;
    run_op(8'h80, 8'h01, lat, bc, ov);
    n_checks++;
    if (lat !== 8 || {bus.diff, bus.borrow_out, bus.overflow, bus.zero} !== {8'h7F, 3'b010}) begin
      n_fail++;
      $display("FAIL overflow_80_01: got lat=%0d diff=%h bo=%b ov=%b z=%b, expected lat=8 diff=7f bo=0 ov=1 z=0",
               lat, bus.diff, bus.borrow_out, bus.overflow, bus.zero);
    end
    run_op(8'h7F, 8'hFF, lat, bc, ov);
    n_checks++;
    if (lat !== 8 || {bus.diff, bus.borrow_out, bus.overflow, bus.zero} !== {8'h80, 3'b110}) begin
      n_fail++;
      $display("FAIL overflow_7f_ff: got lat=%0d diff=%h bo=%b ov=%b z=%b, expected lat=8 diff=80 bo=1 ov=1 z=0",
               lat, bus.diff, bus.borrow_out, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_zero;
    int lat, bc, ov;
    run_op(8'h33, 8'h33, lat, bc, ov);
    n_checks++;
    if (lat !== 8 || {bus.diff, bus.borrow_out, bus.overflow, bus.zero} !== {8'h00, 3'b001}) begin
      n_fail++;
      $display("FAIL zero_33_33: got lat=%0d diff=%h bo=%b ov=%b z=%b, expected lat=8 diff=00 bo=0 ov=0 z=1",
               lat, bus.diff, bus.borrow_out, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vd [3];
    int idx, last, cyc;
    va = '{8'h5A, 8'h10, 8'h80};
    vb = '{8'h23, 8'h20, 8'h01};
    vd = '{8'h37, 8'hF0, 8'h7F};
    idx  = 0;
    last = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = va[0];
    bus.b     = vb[0];
    for (cyc = 1; cyc <= 60 && idx < 3; cyc++) begin
      @(negedge clk);
      if (bus.busy && bus.done) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b_busy_done_overlap: got busy=1 done=1 at cycle %0d, expected never both", cyc);
      end
      if (bus.done) begin
        n_checks++;
        if (bus.diff !== vd[idx]) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: got diff=%h, expected %h", idx, bus.diff, vd[idx]);
        end
        n_checks++;
        if ((idx == 0 && cyc !== 9) || (idx > 0 && cyc - last !== 9)) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: got done at cycle %0d (prev %0d), expected spacing 9", idx, cyc, last);
        end
        last = cyc;
        idx++;
        if (idx < 3) begin
          bus.a = va[idx];
          bus.b = vb[idx];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (idx !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d done pulses, expected 3", idx); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_after: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_ignore_start;
    int pulses, first;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h23;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    first  = 0;
    for (int c = 5; c <= 24; c++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL ignore_start_pulses: got %0d, expected 1", pulses); end
    n_checks++;
    if (first !== 9) begin n_fail++; $display("FAIL ignore_start_latency: got done at cycle %0d, expected 9", first); end
    n_checks++;
    if (bus.diff !== 8'h37 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_result: got diff=%h z=%b, expected diff=37 z=0", bus.diff, bus.zero);
    end
  endtask

  task automatic test_reset_mid;
    int pulses, lat, bc, ov;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.diff, bus.borrow_out, bus.overflow, bus.zero} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got busy=%b done=%b diff=%h bo=%b ov=%b z=%b, expected all 0",
               bus.busy, bus.done, bus.diff, bus.borrow_out, bus.overflow, bus.zero);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d active cycles, expected 0", pulses); end
    run_op(8'h80, 8'h01, lat, bc, ov);
    n_checks++;
    if (lat !== 8 || {bus.diff, bus.borrow_out, bus.overflow, bus.zero} !== {8'h7F, 3'b010}) begin
      n_fail++;
      $display("FAIL reset_mid_fresh_op: got lat=%0d diff=%h bo=%b ov=%b z=%b, expected lat=8 diff=7f bo=0 ov=1 z=0",
               lat, bus.diff, bus.borrow_out, bus.overflow, bus.zero);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
